// File: rtl/train_sequencer_pkg.sv
// Shared definitions for train_sequencer: FSM state encoding, word-width
// derivation and Q(QN.QM) constant helpers.
package train_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_NRST, S_GETS, S_ISSUE,
        S_WNOM, S_GNOM, S_PNOM,
        S_WPRT, S_GPRT, S_PPRT,
        S_SEND, S_WTRN, S_DONE, S_ERR
    } state_e;

    function automatic int q_bitwidth(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

    function automatic longint q_one(input int qm);
        return longint'(1) << qm;
    endfunction

    function automatic longint q_half(input int qm);
        return q_one(qm) >> 1;
    endfunction

    function automatic longint q_sat_max(input int bw);
        return (longint'(1) << (bw - 1)) - 1;
    endfunction

    function automatic longint q_sat_min(input int bw);
        return -(longint'(1) << (bw - 1));
    endfunction

endpackage

// File: rtl/train_sequencer_cost_unit.sv
// Combinational cost datapath: hard sigmoid, squared error, and the
// saturated, scaled difference between a perturbed and a nominal cost.
module cost_unit
    import train_sequencer_pkg::*;
#(
    parameter int QN         = 6,
    parameter int QM         = 11,
    parameter int DIFF_SHIFT = 5,
    parameter int BITWIDTH   = q_bitwidth(QN, QM)
) (
    input  logic signed [BITWIDTH-1:0] perc_out,
    input  logic                       target,
    input  logic signed [BITWIDTH-1:0] j_nom,
    input  logic signed [BITWIDTH-1:0] j_pert,
    output logic signed [BITWIDTH-1:0] j_cur,
    output logic signed [BITWIDTH-1:0] diff
);
    localparam int XW = BITWIDTH + 2;
    localparam int W2 = 2 * BITWIDTH;
    localparam int DW = BITWIDTH + DIFF_SHIFT + 2;

    localparam logic signed [XW-1:0] ONE_X  = XW'(q_one(QM));
    localparam logic signed [XW-1:0] HALF_X = XW'(q_half(QM));

    logic signed [XW-1:0] lin, sig, err;
    logic signed [W2-1:0] sq;
    logic signed [DW-1:0] dlt;
    logic                 sq_unused;

    always_comb begin
        sig  = '0;
        diff = '0;
        lin  = {{2{perc_out[BITWIDTH-1]}}, perc_out >>> 2} + HALF_X;
        if (lin[XW-1])
            sig = '0;
        else if (lin > ONE_X)
            sig = ONE_X;
        else
            sig = lin;
        err   = (target ? ONE_X : '0) - sig;
        sq    = W2'(err) * W2'(err);
        j_cur = BITWIDTH'(sq >>> QM);
        // Wide intermediate so the shift cannot wrap before saturation.
        dlt = (DW'(j_pert) - DW'(j_nom)) <<< DIFF_SHIFT;
        if (dlt > DW'(q_sat_max(BITWIDTH)))
            diff = BITWIDTH'(q_sat_max(BITWIDTH));
        else if (dlt < DW'(q_sat_min(BITWIDTH)))
            diff = BITWIDTH'(q_sat_min(BITWIDTH));
        else
            diff = dlt[BITWIDTH-1:0];
    end

    assign sq_unused = ^{sq[W2-1:QM+BITWIDTH], sq[QM-1:0]};

endmodule

// File: rtl/train_sequencer.sv
// Per-sample training sequencer between the sample source and the LSTM
// network / output perceptron. Optional TRAIN_STATS_EN adds error/sample counters.
module train_sequencer
    import train_sequencer_pkg::*;
#(
    parameter int INPUT_SZ       = 2,
    parameter int QN             = 6,
    parameter int QM             = 11,
    parameter int MAX_SAMPLES    = 8,
    parameter int DIFF_SHIFT     = 5,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int BITWIDTH      = q_bitwidth(QN, QM)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         sampleValid,
    output logic                         sampleReady,
    input  logic [BITWIDTH*INPUT_SZ-1:0] sampleIn,
    input  logic                         targetIn,
    output logic [BITWIDTH*INPUT_SZ-1:0] inputVec,
    output logic                         netReset,
    output logic                         netNewSample,
    input  logic                         netDataReady,
    input  logic                         netTrainingReady,
    output logic                         percReset,
    input  logic                         percDataReady,
    input  logic [BITWIDTH-1:0]          percOut,
    output logic [BITWIDTH-1:0]          costFunc,
    output logic                         newCostFunc,
    output logic                         busy,
    output logic                         seqDone,
`ifdef TRAIN_STATS_EN
    output logic [15:0]                  errCount,
    output logic [15:0]                  sampleCount,
`endif
    output logic                         timeoutErr
);
    localparam int CW = $clog2(MAX_SAMPLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int VW = BITWIDTH * INPUT_SZ;

    state_e                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [WW-1:0]              wd_q, wd_d;
    logic                       nrst_q, nrst_d;
    logic [VW-1:0]              vec_q, vec_d;
    logic                       tgt_q, tgt_d;
    logic signed [BITWIDTH-1:0] j_q, j_d, jp_q, jp_d, cost_q, cost_d;
    logic                       ncf_q, ncf_d;
    logic                       ndr_prev_q, pdr_prev_q, ntr_prev_q;
    logic                       ndr_rise, pdr_rise, ntr_rise, in_wait;
    logic signed [BITWIDTH-1:0] j_cur, diff;
`ifdef TRAIN_STATS_EN
    logic [15:0]                err_cnt_q, err_cnt_d, smp_cnt_q, smp_cnt_d;
`endif

    cost_unit #(
        .QN(QN), .QM(QM), .DIFF_SHIFT(DIFF_SHIFT), .BITWIDTH(BITWIDTH)
    ) u_cost (
        .perc_out ($signed(percOut)),
        .target   (tgt_q),
        .j_nom    (j_q),
        .j_pert   (jp_q),
        .j_cur    (j_cur),
        .diff     (diff)
    );

    // Rise detection against the previous level; a level already high
    // when a wait state is entered never counts.
    assign ndr_rise = netDataReady & ~ndr_prev_q;
    assign pdr_rise = percDataReady & ~pdr_prev_q;
    assign ntr_rise = netTrainingReady & ~ntr_prev_q;
    assign in_wait  = (state_q == S_WNOM) || (state_q == S_PNOM) || (state_q == S_WPRT) ||
                      (state_q == S_PPRT) || (state_q == S_WTRN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wd_d    = '0;
        nrst_d  = 1'b0;
        vec_d   = vec_q;
        tgt_d   = tgt_q;
        j_d     = j_q;
        jp_d    = jp_q;
        cost_d  = cost_q;
        ncf_d   = 1'b0;
`ifdef TRAIN_STATS_EN
        err_cnt_d = err_cnt_q;
        smp_cnt_d = smp_cnt_q;
`endif
        case (state_q)
            S_IDLE, S_ERR: if (start) begin
                state_d = S_NRST;
                cnt_d   = '0;
`ifdef TRAIN_STATS_EN
                err_cnt_d = '0;
                smp_cnt_d = '0;
`endif
            end
            S_NRST: begin
                nrst_d = ~nrst_q;
                if (nrst_q) state_d = S_GETS;
            end
            S_GETS: if (sampleValid) begin
                vec_d   = sampleIn;
                tgt_d   = targetIn;
                state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WNOM;
            S_WNOM:  if (ndr_rise) state_d = S_GNOM;
            S_GNOM:  state_d = S_PNOM;
            S_PNOM:  if (pdr_rise) begin
                j_d     = j_cur;
                state_d = S_WPRT;
`ifdef TRAIN_STATS_EN
                if ((~percOut[BITWIDTH-1] != tgt_q) && (err_cnt_q != 16'hFFFF))
                    err_cnt_d = err_cnt_q + 16'd1;
`endif
            end
            S_WPRT:  if (ndr_rise) state_d = S_GPRT;
            S_GPRT:  state_d = S_PPRT;
            S_PPRT:  if (pdr_rise) begin
                jp_d    = j_cur;
                state_d = S_SEND;
            end
            S_SEND: begin
                cost_d  = diff;
                ncf_d   = 1'b1;
                state_d = S_WTRN;
            end
            S_WTRN: if (ntr_rise) begin
`ifdef TRAIN_STATS_EN
                smp_cnt_d = smp_cnt_q + 16'd1;
`endif
                if (cnt_q == CW'(MAX_SAMPLES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_GETS;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Watchdog restarts on every state change and only runs while stalled.
        if (in_wait && (state_d == state_q)) begin
            if (wd_q == WW'(TIMEOUT_CYCLES - 1))
                state_d = S_ERR;
            else
                wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wd_q       <= '0;
            nrst_q     <= 1'b0;
            vec_q      <= '0;
            tgt_q      <= 1'b0;
            j_q        <= '0;
            jp_q       <= '0;
            cost_q     <= '0;
            ncf_q      <= 1'b0;
            ndr_prev_q <= 1'b0;
            pdr_prev_q <= 1'b0;
            ntr_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
            nrst_q     <= nrst_d;
            vec_q      <= vec_d;
            tgt_q      <= tgt_d;
            j_q        <= j_d;
            jp_q       <= jp_d;
            cost_q     <= cost_d;
            ncf_q      <= ncf_d;
            ndr_prev_q <= netDataReady;
            pdr_prev_q <= percDataReady;
            ntr_prev_q <= netTrainingReady;
        end
    end

`ifdef TRAIN_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            err_cnt_q <= '0;
            smp_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            smp_cnt_q <= smp_cnt_d;
        end
    end

    assign errCount    = err_cnt_q;
    assign sampleCount = smp_cnt_q;
`endif

    assign sampleReady  = (state_q == S_GETS);
    assign netNewSample = (state_q == S_ISSUE);
    assign netReset     = (state_q == S_IDLE) || (state_q == S_NRST) || (state_q == S_ERR);
    assign percReset    = !((state_q == S_PNOM) || (state_q == S_PPRT));
    assign busy         = !((state_q == S_IDLE) || (state_q == S_ERR));
    assign seqDone      = (state_q == S_DONE);
    assign timeoutErr   = (state_q == S_ERR);
    assign inputVec     = vec_q;
    assign costFunc     = cost_q;
    assign newCostFunc  = ncf_q;

endmodule

// File: tb/tb_train_sequencer.sv
// Directed bench for train_sequencer: one DUT with DIFF_SHIFT=5 and a short
// watchdog, a second with DIFF_SHIFT=6 sharing the stimulus for saturation.
module tb_train_sequencer;
    localparam int BW = 18;
    localparam int VW = 2 * BW;

    logic          clock = 1'b0;
    logic          reset, start, sampleValid, targetIn;
    logic          netDataReady, netTrainingReady, percDataReady;
    logic [VW-1:0] sampleIn;
    logic [BW-1:0] percOut;

    logic          a_sampleReady, a_netReset, a_netNewSample, a_percReset;
    logic          a_newCostFunc, a_busy, a_seqDone, a_timeoutErr;
    logic [VW-1:0] a_inputVec;
    logic [BW-1:0] a_costFunc;
    logic          b_sampleReady, b_netReset, b_netNewSample, b_percReset;
    logic          b_newCostFunc, b_busy, b_seqDone, b_timeoutErr;
    logic [VW-1:0] b_inputVec;
    logic [BW-1:0] b_costFunc;
`ifdef TRAIN_STATS_EN
    logic [15:0]   a_errCount, a_sampleCount, b_errCount, b_sampleCount;
`endif

    always #5 clock = ~clock;

    train_sequencer #(.DIFF_SHIFT(5), .TIMEOUT_CYCLES(64)) dut (
        .clock(clock), .reset(reset), .start(start),
        .sampleValid(sampleValid), .sampleReady(a_sampleReady),
        .sampleIn(sampleIn), .targetIn(targetIn), .inputVec(a_inputVec),
        .netReset(a_netReset), .netNewSample(a_netNewSample),
        .netDataReady(netDataReady), .netTrainingReady(netTrainingReady),
        .percReset(a_percReset), .percDataReady(percDataReady), .percOut(percOut),
        .costFunc(a_costFunc), .newCostFunc(a_newCostFunc), .busy(a_busy),
        .seqDone(a_seqDone),
`ifdef TRAIN_STATS_EN
        .errCount(a_errCount), .sampleCount(a_sampleCount),
`endif
        .timeoutErr(a_timeoutErr)
    );

    train_sequencer #(.DIFF_SHIFT(6)) dut6 (
        .clock(clock), .reset(reset), .start(start),
        .sampleValid(sampleValid), .sampleReady(b_sampleReady),
        .sampleIn(sampleIn), .targetIn(targetIn), .inputVec(b_inputVec),
        .netReset(b_netReset), .netNewSample(b_netNewSample),
        .netDataReady(netDataReady), .netTrainingReady(netTrainingReady),
        .percReset(b_percReset), .percDataReady(percDataReady), .percOut(percOut),
        .costFunc(b_costFunc), .newCostFunc(b_newCostFunc), .busy(b_busy),
        .seqDone(b_seqDone),
`ifdef TRAIN_STATS_EN
        .errCount(b_errCount), .sampleCount(b_sampleCount),
`endif
        .timeoutErr(b_timeoutErr)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int ncf_cnt = 0, nrst_cyc = 0, ns_cnt = 0;

    always @(negedge clock) begin
        if (a_newCostFunc) ncf_cnt++;
        if (a_netReset && a_busy) nrst_cyc++;
        if (a_netNewSample) ns_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // From GETS (or just before it) through to the first WNOM cycle.
    task automatic give_sample(input logic t, input logic [VW-1:0] v);
        int k;
        sampleValid = 1'b1;
        sampleIn    = v;
        targetIn    = t;
        k = 0;
        while (!a_sampleReady && k < 16) begin
            step(1);
            k++;
        end
        chk("sample_ready", a_sampleReady, 1);
        step(1);
        sampleValid = 1'b0;
        chk("issue_strobe", a_netNewSample, 1);
        chk("input_vec", a_inputVec, v);
        step(1);
        chk("issue_one_cycle", a_netNewSample, 0);
    endtask

    task automatic nom_pass(input logic [BW-1:0] pn);
        netDataReady = 1'b1;
        step(2);
        chk("pnom_perc_enabled", a_percReset, 0);
        percOut       = pn;
        percDataReady = 1'b1;
        step(1);
        percDataReady = 1'b0;
        netDataReady  = 1'b0;
        chk("wprt_perc_disabled", a_percReset, 1);
    endtask

    task automatic prt_pass();
        step(1);
        netDataReady = 1'b1;
        step(2);
        chk("pprt_perc_enabled", a_percReset, 0);
    endtask

    task automatic finish(input logic [BW-1:0] pp, input logic [BW-1:0] e5,
                          input logic [BW-1:0] e6, input bit check6);
        percOut       = pp;
        percDataReady = 1'b1;
        step(1);
        percDataReady = 1'b0;
        netDataReady  = 1'b0;
        chk("no_early_strobe", a_newCostFunc, 0);
        step(1);
        chk("cost_strobe", a_newCostFunc, 1);
        chk("cost_value", a_costFunc, e5);
        if (check6) chk("cost_value_shift6", b_costFunc, e6);
        step(1);
        chk("strobe_one_cycle", a_newCostFunc, 0);
        chk("cost_held", a_costFunc, e5);
        netTrainingReady = 1'b1;
        step(1);
        netTrainingReady = 1'b0;
    endtask

    logic          t_tab  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [BW-1:0] pn_tab [8] = '{18'h00000, 18'h38000, 18'h00000, 18'h01000,
                                  18'h3F000, 18'h38000, 18'h00400, 18'h00004};
    logic [BW-1:0] pp_tab [8] = '{18'h01000, 18'h08000, 18'h00000, 18'h00000,
                                  18'h00800, 18'h08000, 18'h3FC00, 18'h00000};
    logic [BW-1:0] e5_tab [8] = '{18'h3C000, 18'h10000, 18'h00000, 18'h04000,
                                  18'h09000, 18'h30000, 18'h04000, 18'h3FFE0};
    logic [BW-1:0] e6_tab [8] = '{18'h38000, 18'h1FFFF, 18'h00000, 18'h08000,
                                  18'h12000, 18'h20000, 18'h08000, 18'h3FFC0};

    initial begin
        int ncf0, nrst0, ns0;
        reset = 1'b1; start = 1'b0; sampleValid = 1'b0; targetIn = 1'b0;
        netDataReady = 1'b0; netTrainingReady = 1'b0; percDataReady = 1'b0;
        sampleIn = '0; percOut = '0;
        step(2);
        chk("rst_netReset", a_netReset, 1);
        chk("rst_percReset", a_percReset, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_sampleReady", a_sampleReady, 0);
        chk("rst_newSample", a_netNewSample, 0);
        chk("rst_costFunc", a_costFunc, 0);
        chk("rst_newCostFunc", a_newCostFunc, 0);
        chk("rst_seqDone", a_seqDone, 0);
        chk("rst_timeoutErr", a_timeoutErr, 0);
        chk("rst_inputVec", a_inputVec, 0);
        reset = 1'b0;
        step(2);
        chk("idle_busy", a_busy, 0);

        // Full eight-sample run
        ncf0 = ncf_cnt; nrst0 = nrst_cyc;
        start = 1'b1; step(1); start = 1'b0;
        chk("nrst1_busy", a_busy, 1);
        chk("nrst1_netReset", a_netReset, 1);
        step(1);
        chk("nrst2_netReset", a_netReset, 1);
        step(1);
        chk("gets_netReset_low", a_netReset, 0);
        chk("gets_ready", a_sampleReady, 1);
        for (int i = 0; i < 8; i++) begin
            give_sample(t_tab[i], {18'(i + 1), 18'(100 - i)});
            nom_pass(pn_tab[i]);
            prt_pass();
            finish(pp_tab[i], e5_tab[i], e6_tab[i], 1'b1);
        end
        chk("run_seqDone", a_seqDone, 1);
        step(1);
        chk("run_seqDone_pulse", a_seqDone, 0);
        chk("run_idle", a_busy, 0);
        chk("run_cost_pulses", 64'(ncf_cnt - ncf0), 8);
        chk("run_netReset_cycles", 64'(nrst_cyc - nrst0), 2);

        // Stall in GETS, then start ignored during WNOM
        start = 1'b1; step(1); start = 1'b0;
        step(2);
        chk("stall_entry_ready", a_sampleReady, 1);
        ns0 = ns_cnt;
        step(20);
        chk("stall_ready", a_sampleReady, 1);
        chk("stall_no_timeout", a_timeoutErr, 0);
        chk("stall_no_strobe", 64'(ns_cnt - ns0), 0);
        give_sample(1'b1, 36'h0_1234_5678);
        start = 1'b1; step(1); start = 1'b0;
        chk("start_ignored_busy", a_busy, 1);
        chk("start_ignored_netReset", a_netReset, 0);
        nom_pass(18'h00000);
        prt_pass();
        finish(18'h01000, 18'h3C000, 18'h00000, 1'b0);

        // Watchdog: netDataReady never arrives
        give_sample(1'b0, 36'h9_8765_4321);
        step(63);
        chk("timeout_not_early", a_timeoutErr, 0);
        step(1);
        chk("timeout_at_64", a_timeoutErr, 1);
        chk("err_busy", a_busy, 0);
        chk("err_netReset", a_netReset, 1);
        chk("err_percReset", a_percReset, 1);
        step(3);
        chk("timeout_sticky", a_timeoutErr, 1);
        start = 1'b1; step(1); start = 1'b0;
        chk("err_start_clears", a_timeoutErr, 0);
        chk("err_start_nrst", a_netReset, 1);
        chk("err_start_busy", a_busy, 1);

        // Reset during PPRT, then a fresh run
        step(2);
        give_sample(1'b1, 36'h0_0000_00FF);
        nom_pass(18'h00000);
        prt_pass();
        reset = 1'b1; netDataReady = 1'b0;
        step(1);
        chk("midrst_netReset", a_netReset, 1);
        chk("midrst_percReset", a_percReset, 1);
        chk("midrst_busy", a_busy, 0);
        chk("midrst_costFunc", a_costFunc, 0);
        reset = 1'b0;
        step(1);
        nrst0 = nrst_cyc;
        start = 1'b1; step(1); start = 1'b0;
        chk("fresh_nrst", a_netReset, 1);
        step(2);
        chk("fresh_gets", a_sampleReady, 1);
        chk("fresh_nrst_cycles", 64'(nrst_cyc - nrst0), 2);
        give_sample(1'b1, 36'h5_5555_5555);
        nom_pass(18'h01000);
        prt_pass();
        finish(18'h00000, 18'h04000, 18'h00000, 1'b0);
        chk("fresh_back_to_gets", a_sampleReady, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
